wakeup_broadcaster: RTL and testbench

- Producer side of the wakeup bus that Rename consumes (wakeup_active / wakeup_tag / wakeup_value).
- Collects completed results from NUM_FU functional units, each into its own small queue.
- Round-robin arbitrates among the queues and drives exactly one registered wakeup broadcast per cycle to Rename and the reservation stations.

---
 rtl/wakeup_broadcaster_pkg.sv | 18 +
 rtl/wakeup_broadcaster_result_fifo.sv | 49 ++++
 rtl/wakeup_broadcaster.sv | 117 +++++++++++
 tb/tb_wakeup_broadcaster.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wakeup_broadcaster_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wakeup_broadcaster_pkg : shared wakeup-bus widths, payload type, x0 tag
// Revision : 1.0
// ---------------------------------------------------------------------------
package wakeup_broadcaster_pkg;

  localparam int TAG_W    = 6;
  localparam int DATA_W   = 32;
  localparam int ZERO_TAG = 0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } wakeup_t;

endpackage
`default_nettype wire

// File: rtl/wakeup_broadcaster_result_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_result_fifo : per-FU result queue with registered count and head output
// Revision : 1.0
// ---------------------------------------------------------------------------
module wb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/wakeup_broadcaster.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wakeup_broadcaster : per-FU result queues, round-robin arbitrated into one
//                      registered wakeup broadcast per cycle.
//                      WAKEUP_BYPASS_EN lets an incoming result win directly.
// Revision : 1.0
// ---------------------------------------------------------------------------
module wakeup_broadcaster #(
  parameter int NUM_FU     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = wakeup_broadcaster_pkg::TAG_W,
  parameter int DATA_W     = wakeup_broadcaster_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_value,
  output logic                     wakeup_active,
  output logic [TAG_W-1:0]         wakeup_tag,
  output logic [DATA_W-1:0]        wakeup_value
);

  import wakeup_broadcaster_pkg::*;

  localparam int EW    = TAG_W + DATA_W;
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] xfer;
  logic [NUM_FU-1:0] nonzero;
  logic [NUM_FU-1:0] cand;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] grant_oh;
  logic [EW-1:0]     in_data [NUM_FU];
  logic [EW-1:0]     head    [NUM_FU];

  logic              grant_valid;
  logic [PTR_W-1:0]  grant_idx;
  logic [EW-1:0]     grant_data;
  logic [PTR_W-1:0]  rr_ptr;

  generate
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign in_data[i] = {fu_tag[i*TAG_W +: TAG_W], fu_value[i*DATA_W +: DATA_W]};
      assign nonzero[i] = (fu_tag[i*TAG_W +: TAG_W] != TAG_W'(ZERO_TAG));

      wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push[i]),
        .din   (in_data[i]),
        .pop   (pop[i]),
        .full  (full[i]),
        .empty (empty[i]),
        .head  (head[i])
      );
    end
  endgenerate

  assign fu_ready = ~full;
  assign xfer     = fu_valid & fu_ready;

`ifdef WAKEUP_BYPASS_EN
  assign cand = ~empty | (xfer & nonzero);
`else
  assign cand = ~empty;
`endif

  function automatic int wrap_idx(input int base, input int ofs);
    return (base + ofs) % NUM_FU;
  endfunction

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    grant_oh    = '0;
    for (int k = 1; k <= NUM_FU; k++) begin
      if (!grant_valid && cand[wrap_idx(int'(rr_ptr), k)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(wrap_idx(int'(rr_ptr), k));
        grant_oh[wrap_idx(int'(rr_ptr), k)] = 1'b1;
        grant_data  = empty[wrap_idx(int'(rr_ptr), k)] ? in_data[wrap_idx(int'(rr_ptr), k)]
                                                      : head[wrap_idx(int'(rr_ptr), k)];
      end
    end
  end

  // A granted result taken straight from the FU port never enters its queue.
  assign pop  = grant_oh & ~empty;
  assign push = xfer & nonzero & ~(grant_oh & empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= PTR_W'(NUM_FU - 1);
      wakeup_active <= 1'b0;
      wakeup_tag    <= '0;
      wakeup_value  <= '0;
    end else begin
      wakeup_active <= grant_valid;
      if (grant_valid) begin
        rr_ptr       <= grant_idx;
        wakeup_tag   <= grant_data[EW-1 -: TAG_W];
        wakeup_value <= grant_data[DATA_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wakeup_broadcaster.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wakeup_broadcaster : directed self-checking bench for wakeup_broadcaster
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_wakeup_broadcaster;

  localparam int NUM_FU = 3;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU*TAG_W-1:0]  fu_tag;
  logic [NUM_FU*DATA_W-1:0] fu_value;
  logic                     wakeup_active;
  logic [TAG_W-1:0]         wakeup_tag;
  logic [DATA_W-1:0]        wakeup_value;

  int checks = 0;
  int errors = 0;

  wakeup_broadcaster #(
    .NUM_FU     (NUM_FU),
    .FIFO_DEPTH (4),
    .TAG_W      (TAG_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fu_valid      (fu_valid),
    .fu_ready      (fu_ready),
    .fu_tag        (fu_tag),
    .fu_value      (fu_value),
    .wakeup_active (wakeup_active),
    .wakeup_tag    (wakeup_tag),
    .wakeup_value  (wakeup_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int fu, input int tag, input int value);
    fu_valid[fu]                  = 1'b1;
    fu_tag[fu*TAG_W +: TAG_W]     = TAG_W'(tag);
    fu_value[fu*DATA_W +: DATA_W] = DATA_W'(value);
  endtask

  task automatic expect_bcast(input string tag, input int exp_tag, input int exp_value);
    check({tag, "_active"}, 64'(wakeup_active), 64'd1);
    check({tag, "_tag"},    64'(wakeup_tag),    64'(exp_tag));
    check({tag, "_value"},  64'(wakeup_value),  64'(exp_value));
  endtask

  int  exp_q [NUM_FU][$];
  int  next_tag [NUM_FU];
  bit  acc [NUM_FU];
  bit  saw_full;
  int  src;
  int  exp_t;

  task automatic score_bcast();
    if (wakeup_active) begin
      src = int'(wakeup_tag) / 16 - 1;
      if (src >= 0 && src < NUM_FU && exp_q[src].size() > 0) begin
        exp_t = exp_q[src].pop_front();
        check("stream_tag",   64'(wakeup_tag),   64'(exp_t));
        check("stream_value", 64'(wakeup_value), 64'(exp_t + 1000));
      end else begin
        check("stream_unexpected_tag", 64'(wakeup_tag), 64'hFFFF);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("reset_active", 64'(wakeup_active), 64'd0);
    check("reset_tag",    64'(wakeup_tag),    64'd0);
    check("reset_value",  64'(wakeup_value),  64'd0);
    check("reset_ready",  64'(fu_ready),      64'h7);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int n = 0; n < 5; n++) begin
      tick();
      check("idle_active", 64'(wakeup_active), 64'd0);
    end
    check("idle_tag",   64'(wakeup_tag),   64'd0);
    check("idle_value", 64'(wakeup_value), 64'd0);

    // 2: single result, one-cycle latency, then hold
    offer(1, 5, 123);
    tick();
    fu_valid = '0;
    check("single_push_edge_active", 64'(wakeup_active), 64'd0);
    tick();
    expect_bcast("single", 5, 123);
    tick();
    check("single_after_active", 64'(wakeup_active), 64'd0);
    check("single_hold_tag",     64'(wakeup_tag),    64'd5);
    check("single_hold_value",   64'(wakeup_value),  64'd123);

    // 3a: rr_ptr=1 so FU2 goes first, then FU0, FU1
    offer(0, 1, 11);
    offer(1, 2, 22);
    offer(2, 3, 33);
    tick();
    fu_valid = '0;
    tick(); expect_bcast("rr3_first",  3, 33);
    tick(); expect_bcast("rr3_second", 1, 11);
    tick(); expect_bcast("rr3_third",  2, 22);
    tick();
    check("rr3_idle", 64'(wakeup_active), 64'd0);

    // 3b: rr_ptr=1, FU2 and FU0 only
    offer(0, 8, 88);
    offer(2, 9, 99);
    tick();
    fu_valid = '0;
    tick(); expect_bcast("rr2_first",  9, 99);
    tick(); expect_bcast("rr2_second", 8, 88);
    tick();

    // 4a: FU0 alone streams; single pop per cycle keeps it ready
    for (int i = 0; i < 6; i++) begin
      offer(0, 10 + i, 500 + i);
      check("solo_ready0", 64'(fu_ready[0]), 64'd1);
      tick();
      if (i > 0) expect_bcast("solo", 10 + i - 1, 500 + i - 1);
    end
    fu_valid = '0;
    tick();
    expect_bcast("solo_last", 15, 505);
    tick();

    // 4b: all FUs stream; FU0 fills, no loss or reorder
    next_tag = '{16, 32, 48};
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        offer(f, next_tag[f], next_tag[f] + 1000);
        acc[f] = fu_ready[f];
        if (acc[f]) exp_q[f].push_back(next_tag[f]);
      end
      if (!fu_ready[0]) saw_full = 1'b1;
      tick();
      for (int f = 0; f < NUM_FU; f++) if (acc[f]) next_tag[f]++;
      score_bcast();
    end
    fu_valid = '0;
    for (int n = 0; n < 30; n++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
      tick();
      score_bcast();
    end
    check("stream_saw_ready0_low", 64'(saw_full),        64'd1);
    check("stream_left_fu0",       64'(exp_q[0].size()), 64'd0);
    check("stream_left_fu1",       64'(exp_q[1].size()), 64'd0);
    check("stream_left_fu2",       64'(exp_q[2].size()), 64'd0);
    tick();
    check("stream_drained", 64'(wakeup_active), 64'd0);

    // 5: tag 0 accepted and discarded
    offer(2, 0, 999);
    check("x0_ready", 64'(fu_ready[2]), 64'd1);
    tick();
    fu_valid = '0;
    for (int n = 0; n < 3; n++) begin
      check("x0_no_bcast", 64'(wakeup_active), 64'd0);
      tick();
    end

    // 6: fresh reset gives 1,2,3 order; then async reset mid-operation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    offer(0, 1, 101);
    offer(1, 2, 102);
    offer(2, 3, 103);
    tick();
    fu_valid = '0;
    check("order_push_edge", 64'(wakeup_active), 64'd0);
    tick(); expect_bcast("order_a", 1, 101);
    tick(); expect_bcast("order_b", 2, 102);
    tick(); expect_bcast("order_c", 3, 103);

    offer(0, 4, 104);
    offer(1, 5, 105);
    offer(2, 6, 106);
    tick();
    fu_valid = '0;
    tick();
    expect_bcast("pre_reset", 4, 104);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_active", 64'(wakeup_active), 64'd0);
    check("async_rst_tag",    64'(wakeup_tag),    64'd0);
    check("async_rst_value",  64'(wakeup_value),  64'd0);
    check("async_rst_ready",  64'(fu_ready),      64'h7);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("post_rst_no_stale", 64'(wakeup_active), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
